// File: rtl/floor_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : floor_scheduler_if
// Description : Control inputs and floor slot outputs of the floor scheduler.
//               The game controller side is the master; the scheduler is the
//               slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface floor_scheduler_if;
  logic        run;
  logic        tick;
  logic [10:0] floor_pos_x0;
  logic [10:0] floor_pos_x1;
  logic [10:0] floor_pos_x2;
  logic [10:0] floor_pos_x3;
  logic [10:0] floor_pos_y0;
  logic [10:0] floor_pos_y1;
  logic [10:0] floor_pos_y2;
  logic [10:0] floor_pos_y3;
  logic [3:0]  enable;
  logic        busy;
  logic        spawn_pulse;
  logic        retire_pulse;

  modport master (
    output run, tick,
    input  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    input  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    input  enable, busy, spawn_pulse, retire_pulse
  );

  modport slave (
    input  run, tick,
    output floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    output floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    output enable, busy, spawn_pulse, retire_pulse
  );
endinterface
`default_nettype wire

// File: rtl/floor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : floor_scheduler
// Description : Owns four floor slots. Each accepted scroll tick runs
//               SCROLL -> RETIRE -> SPAWN; new floor x positions come from a
//               16-bit Fibonacci LFSR folded into the legal spawn range.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_scheduler #(
  parameter int          SCREEN_W = 640,
  parameter int          SPAWN_Y  = 480,
  parameter int          FLOOR_W  = 120,
  parameter int          STEP     = 2,
  parameter int          GAP      = 120,
  parameter int          TOP_Y    = 0,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  floor_scheduler_if.slave  bus
);

  localparam logic [10:0] c_STEP     = 11'(STEP);
  localparam logic [10:0] c_GAP      = 11'(GAP);
  localparam logic [10:0] c_TOP_Y    = 11'(TOP_Y);
  localparam logic [10:0] c_SPAWN_Y  = 11'(SPAWN_Y);
  localparam logic [9:0]  c_XR_RANGE = 10'(SCREEN_W - FLOOR_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_RETIRE = 2'd2,
    ST_SPAWN  = 2'd3
  } state_t;

  state_t      r_state;
  logic [10:0] r_x [4];
  logic [10:0] r_y [4];
  logic [3:0]  r_en;
  logic [10:0] r_gap;
  logic [15:0] r_lfsr;
  logic        r_busy;
  logic        r_spawn;
  logic        r_retire;

  logic [10:0] w_gap_sum;
  logic [10:0] w_gap_sat;
  logic [3:0]  w_retire_mask;
  logic        w_any_free;
  logic [1:0]  w_free_idx;
  logic        w_fb;
  logic [15:0] w_lfsr_next;
  logic [9:0]  w_l10;
  logic [10:0] w_xr;

  // Saturating gap counter, retire candidates, lowest free slot and spawn x
  always_comb begin
    w_gap_sum = r_gap + c_STEP;
    w_gap_sat = (w_gap_sum > c_GAP) ? c_GAP : w_gap_sum;
    for (int i = 0; i < 4; i++) begin
      w_retire_mask[i] = r_en[i] && (r_y[i] <= c_TOP_Y);
    end
    w_any_free = ~&r_en;
    w_free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_en[i]) begin
        w_free_idx = 2'(i);
      end
    end
    w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    w_lfsr_next = {r_lfsr[14:0], w_fb};
    w_l10       = r_lfsr[9:0];
    // A single subtraction suffices: 1023 - 520 is still below 520
    w_xr        = {1'b0, (w_l10 < c_XR_RANGE) ? w_l10 : (w_l10 - c_XR_RANGE)};
  end

  // Sequencer and all slot state; every output is a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_en     <= 4'b0000;
      r_gap    <= c_GAP;
      r_lfsr   <= SEED;
      r_busy   <= 1'b0;
      r_spawn  <= 1'b0;
      r_retire <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_spawn  <= 1'b0;
      r_retire <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.run && bus.tick) begin
            r_state <= ST_SCROLL;
            r_busy  <= 1'b1;
          end
        end
        ST_SCROLL: begin
          for (int i = 0; i < 4; i++) begin
            if (r_en[i]) begin
              r_y[i] <= (r_y[i] >= c_STEP) ? (r_y[i] - c_STEP) : '0;
            end
          end
          r_gap   <= w_gap_sat;
          r_state <= ST_RETIRE;
        end
        ST_RETIRE: begin
          // Retired slots keep stale x/y; only the enable bit drops
          r_en     <= r_en & ~w_retire_mask;
          r_retire <= |w_retire_mask;
          r_state  <= ST_SPAWN;
        end
        ST_SPAWN: begin
          if ((r_gap == c_GAP) && w_any_free) begin
            r_en[w_free_idx] <= 1'b1;
            r_y[w_free_idx]  <= c_SPAWN_Y;
            r_x[w_free_idx]  <= w_xr;
            r_gap            <= '0;
            r_lfsr           <= w_lfsr_next;
            r_spawn          <= 1'b1;
          end
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.floor_pos_x0 = r_x[0];
  assign bus.floor_pos_x1 = r_x[1];
  assign bus.floor_pos_x2 = r_x[2];
  assign bus.floor_pos_x3 = r_x[3];
  assign bus.floor_pos_y0 = r_y[0];
  assign bus.floor_pos_y1 = r_y[1];
  assign bus.floor_pos_y2 = r_y[2];
  assign bus.floor_pos_y3 = r_y[3];
  assign bus.enable       = r_en;
  assign bus.busy         = r_busy;
  assign bus.spawn_pulse  = r_spawn;
  assign bus.retire_pulse = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_floor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_scheduler
// Description : Self-checking bench for floor_scheduler. Two instances run
//               side by side on identical stimulus: the default GAP=120 one
//               and a GAP=20 one that fills all four slots and saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_scheduler;

  logic clk;
  logic rst_n;
  logic run;
  logic tick;

  int n_checks;
  int n_err;

  floor_scheduler_if bus0 ();
  floor_scheduler_if bus1 ();

  assign bus0.run  = run;
  assign bus0.tick = tick;
  assign bus1.run  = run;
  assign bus1.tick = tick;

  floor_scheduler u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  floor_scheduler #(.GAP(20)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Observed outputs gathered into arrays, index [instance][slot]
  logic [10:0] ox [2][4];
  logic [10:0] oy [2][4];
  logic [3:0]  oen [2];
  logic        obusy [2];
  logic        ospawn [2];
  logic        oret [2];

  assign ox[0][0] = bus0.floor_pos_x0;  assign oy[0][0] = bus0.floor_pos_y0;
  assign ox[0][1] = bus0.floor_pos_x1;  assign oy[0][1] = bus0.floor_pos_y1;
  assign ox[0][2] = bus0.floor_pos_x2;  assign oy[0][2] = bus0.floor_pos_y2;
  assign ox[0][3] = bus0.floor_pos_x3;  assign oy[0][3] = bus0.floor_pos_y3;
  assign ox[1][0] = bus1.floor_pos_x0;  assign oy[1][0] = bus1.floor_pos_y0;
  assign ox[1][1] = bus1.floor_pos_x1;  assign oy[1][1] = bus1.floor_pos_y1;
  assign ox[1][2] = bus1.floor_pos_x2;  assign oy[1][2] = bus1.floor_pos_y2;
  assign ox[1][3] = bus1.floor_pos_x3;  assign oy[1][3] = bus1.floor_pos_y3;
  assign oen[0] = bus0.enable;  assign obusy[0] = bus0.busy;
  assign oen[1] = bus1.enable;  assign obusy[1] = bus1.busy;
  assign ospawn[0] = bus0.spawn_pulse;  assign oret[0] = bus0.retire_pulse;
  assign ospawn[1] = bus1.spawn_pulse;  assign oret[1] = bus1.retire_pulse;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          gmax [2];
  int          mx [2][4];
  int          my [2][4];
  bit          men [2][4];
  int          mgap [2];
  logic [15:0] mlfsr [2];
  // snapshots after the scroll and retire phases of the last tick
  int          sy [2][4];
  bit          sen [2][4];
  bit          sret [2];
  bit          sspw [2];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int x_from(input logic [15:0] l);
    int v;
    v = int'(l) % 1024;
    return (v < 520) ? v : v - 520;
  endfunction

  function automatic logic [3:0] en_vec(input bit e [4]);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = e[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mgap[k]  = gmax[k];
      mlfsr[k] = 16'hACE1;
      for (int i = 0; i < 4; i++) begin
        mx[k][i] = 0; my[k][i] = 0; men[k][i] = 0;
      end
    end
  endtask

  task automatic model_tick();
    int tgt;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (men[k][i]) my[k][i] = (my[k][i] >= 2) ? my[k][i] - 2 : 0;
        sy[k][i] = my[k][i];
      end
      mgap[k] = (mgap[k] + 2 > gmax[k]) ? gmax[k] : mgap[k] + 2;
      sret[k] = 0;
      for (int i = 0; i < 4; i++) begin
        if (men[k][i] && my[k][i] <= 0) begin
          men[k][i] = 0;
          sret[k]   = 1;
        end
        sen[k][i] = men[k][i];
      end
      sspw[k] = 0;
      tgt = -1;
      for (int i = 3; i >= 0; i--) if (!men[k][i]) tgt = i;
      if (mgap[k] == gmax[k] && tgt >= 0) begin
        men[k][tgt] = 1;
        my[k][tgt]  = 480;
        mx[k][tgt]  = x_from(mlfsr[k]);
        mlfsr[k]    = lfsr_step(mlfsr[k]);
        mgap[k]     = 0;
        sspw[k]     = 1;
      end
    end
  endtask

  // One accepted tick, checked phase by phase.
  // mode 0: plain; 1: tick held high through the busy window; 2: run drops mid-sequence
  task automatic do_tick(input int mode);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    model_tick();
    if (mode == 1) tick = 1'b1;
    if (mode == 2) run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obusy[k] !== 1'b1) begin
        n_err++; $display("FAIL busy_scroll inst%0d got=%0d exp=1", k, obusy[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (oy[k][i] !== 11'(sy[k][i])) begin
          n_err++; $display("FAIL scroll_y inst%0d slot%0d got=%0d exp=%0d", k, i, oy[k][i], sy[k][i]);
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (oen[k] !== en_vec(sen[k]) || oret[k] !== sret[k]) begin
        n_err++; $display("FAIL retire inst%0d got en=%b pulse=%0d exp en=%b pulse=%0d",
                          k, oen[k], oret[k], en_vec(sen[k]), sret[k]);
      end
    end
    @(negedge clk);
    tick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obusy[k] !== 1'b0 || ospawn[k] !== sspw[k] || oen[k] !== en_vec(men[k])) begin
        n_err++; $display("FAIL spawn inst%0d got busy=%0d pulse=%0d en=%b exp busy=0 pulse=%0d en=%b",
                          k, obusy[k], ospawn[k], oen[k], sspw[k], en_vec(men[k]));
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ox[k][i] !== 11'(mx[k][i]) || oy[k][i] !== 11'(my[k][i])) begin
          n_err++; $display("FAIL slot_pos inst%0d slot%0d got x=%0d y=%0d exp x=%0d y=%0d",
                            k, i, ox[k][i], oy[k][i], mx[k][i], my[k][i]);
        end
      end
    end
    if (mode == 2) run = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (oen[k] !== 4'b0 || obusy[k] !== 1'b0 || ospawn[k] !== 1'b0 || oret[k] !== 1'b0) begin
        n_err++; $display("FAIL reset_ctl inst%0d got en=%b busy=%0d sp=%0d rt=%0d exp all 0",
                          k, oen[k], obusy[k], ospawn[k], oret[k]);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ox[k][i] !== 11'd0 || oy[k][i] !== 11'd0) begin
          n_err++; $display("FAIL reset_pos inst%0d slot%0d got x=%0d y=%0d exp 0", k, i, ox[k][i], oy[k][i]);
        end
      end
    end
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  task automatic test_first_spawn();
    do_tick(0);
    n_checks++;
    if (oen[0] !== 4'b0001 || oy[0][0] !== 11'd480 || ox[0][0] !== 11'd225) begin
      n_err++; $display("FAIL first_spawn got en=%b y0=%0d x0=%0d exp en=0001 y0=480 x0=225",
                        oen[0], oy[0][0], ox[0][0]);
    end
  endtask

  task automatic test_second_spawn();
    repeat (60) do_tick(0);
    n_checks++;
    if (oen[0] !== 4'b0011 || oy[0][0] !== 11'd360 || oy[0][1] !== 11'd480 || ox[0][1] !== 11'd451) begin
      n_err++; $display("FAIL second_spawn got en=%b y0=%0d y1=%0d x1=%0d exp en=0011 y0=360 y1=480 x1=451",
                        oen[0], oy[0][0], oy[0][1], ox[0][1]);
    end
  endtask

  // Runs to tick 241 where slot0 reaches the top and is respawned at once
  task automatic test_retire_reuse();
    repeat (179) do_tick(0);
    n_checks++;
    if (oen[0] !== 4'b1111 || oen[1] !== 4'b1111 || oy[0][0] !== 11'd2) begin
      n_err++; $display("FAIL full_slots got en0=%b en1=%b y0=%0d exp en0=1111 en1=1111 y0=2",
                        oen[0], oen[1], oy[0][0]);
    end
    do_tick(0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (oen[k] !== 4'b1111 || oy[k][0] !== 11'd480 || sret[k] !== 1'b1 || sspw[k] !== 1'b1) begin
        n_err++; $display("FAIL slot_reuse inst%0d got en=%b y0=%0d exp en=1111 y0=480", k, oen[k], oy[k][0]);
      end
    end
  endtask

  task automatic test_drop_run();
    run = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obusy[k] !== 1'b0) begin
          n_err++; $display("FAIL drop_run_busy inst%0d got=%0d exp=0", k, obusy[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (oen[k] !== en_vec(men[k])) begin
        n_err++; $display("FAIL drop_run_en inst%0d got=%b exp=%b", k, oen[k], en_vec(men[k]));
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ox[k][i] !== 11'(mx[k][i]) || oy[k][i] !== 11'(my[k][i])) begin
          n_err++; $display("FAIL drop_run_pos inst%0d slot%0d got x=%0d y=%0d exp x=%0d y=%0d",
                            k, i, ox[k][i], oy[k][i], mx[k][i], my[k][i]);
        end
      end
    end
    run = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_tick(1);
    do_tick(1);
    do_tick(2);
    do_tick(0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (oen[k] !== 4'b0 || obusy[k] !== 1'b0 || oret[k] !== 1'b0 ||
          ox[k][0] !== 11'd0 || oy[k][0] !== 11'd0 || oy[k][3] !== 11'd0) begin
        n_err++; $display("FAIL reset_mid inst%0d got en=%b busy=%0d rt=%0d y0=%0d exp all 0",
                          k, oen[k], obusy[k], oret[k], oy[k][0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_tick(0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ox[k][0] !== 11'd225 || oen[k] !== 4'b0001) begin
        n_err++; $display("FAIL reset_respawn inst%0d got x0=%0d en=%b exp x0=225 en=0001", k, ox[k][0], oen[k]);
      end
    end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0)      test_drop_run();
      else if (op == 1) do_tick(1);
      else if (op == 2) do_tick(2);
      else              do_tick(0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    gmax[0]  = 120;
    gmax[1]  = 20;
    test_reset();
    test_first_spawn();
    test_second_spawn();
    test_retire_reuse();
    test_drop_run();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
